// File: rtl/filter_mode_ctrl_if.sv
// filter_mode_ctrl_if: VGA timing in, pixel position out.
//   master : drives iVGA_HS / iVGA_VS / iVGA_BLANK_N, observes position
//   slave  : filter_mode_ctrl side, samples timing, drives
//            pix_x / pix_y / pix_valid / frame_start
interface filter_mode_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          iVGA_HS;
    logic          iVGA_VS;
    logic          iVGA_BLANK_N;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_valid;
    logic          frame_start;

    modport master (
        output iVGA_HS, iVGA_VS, iVGA_BLANK_N,
        input  pix_x, pix_y, pix_valid, frame_start
    );

    modport slave (
        input  iVGA_HS, iVGA_VS, iVGA_BLANK_N,
        output pix_x, pix_y, pix_valid, frame_start
    );
endinterface

// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: channel-enable control for the VGA pixel-delta filter.
// Key requests build a pending mask; the mask is committed to ch_en only on
// the VS falling edge so a mode change never tears a frame. Also tracks
// pixel position and checks frame geometry.
//
// Ports:
//   VGA_CLK, reset_n      pixel clock, async active-low reset
//   vga (slave)           VGA sync/blank in; pix_x/pix_y/pix_valid/frame_start out
//   KEY[1:0]              active-low buttons: [0] next mode, [1] load SW
//   SW[2:0]               channel mask source {B,G,R}
//   ch_en, pend_en        committed / pending channel mask
//   line_err, frame_err   sticky geometry errors
//   LEDR[9:0]             {active, frame cnt[0], frame_err, line_err, pend_en, ch_en}
//
// Build option: define FILTER_CTRL_DEBOUNCE_EN to debounce each key for
// DEBOUNCE_CYC stable cycles before press detection.
module filter_mode_ctrl #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int XW           = $clog2(WIDTH + 1),
    parameter int YW           = $clog2(HEIGHT + 1),
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic              VGA_CLK,
    input  logic              reset_n,
    filter_mode_ctrl_if.slave vga,
    input  logic [1:0]        KEY,
    input  logic [2:0]        SW,
    output logic [2:0]        ch_en,
    output logic [2:0]        pend_en,
    output logic              line_err,
    output logic              frame_err,
    output logic [9:0]        LEDR
);
    typedef enum logic [1:0] {WAIT_VS, VSYNC, VBLANK, ACTIVE} state_t;

    localparam logic [XW-1:0] X_FULL = XW'(WIDTH);
    localparam logic [YW-1:0] Y_FULL = YW'(HEIGHT);

    state_t        state, stateNext;
    logic [1:0]    keyMeta, keySync, keyLvl, keyPrev, press;
    logic [2:0]    swMeta, swSync;
    logic          vsR, vsFall;
    logic          countEn, checkEn, isActive;
    logic [XW-1:0] x, pixX;
    logic [YW-1:0] y, pixY;
    logic          pixValid, frameStart;
    logic [7:0]    frameCnt;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            keyMeta <= '0;
            keySync <= '0;
            swMeta  <= '0;
            swSync  <= '0;
        end else begin
            keyMeta <= KEY;
            keySync <= keyMeta;
            swMeta  <= SW;
            swSync  <= swMeta;
        end
    end

`ifdef FILTER_CTRL_DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);

    // One stability counter per key; the level only moves after the new
    // synchronised value has held for DEBOUNCE_CYC consecutive cycles.
    for (genvar k = 0; k < 2; k++) begin : g_deb
        logic           lvl;
        logic [DCW-1:0] cnt;

        always_ff @(posedge VGA_CLK or negedge reset_n) begin
            if (!reset_n) begin
                lvl <= 1'b0;
                cnt <= '0;
            end else if (keySync[k] == lvl) begin
                cnt <= '0;
            end else if (cnt == DCW'(DEBOUNCE_CYC - 1)) begin
                lvl <= keySync[k];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign keyLvl[k] = lvl;
    end
`else
    assign keyLvl = keySync;
`endif

    // Registers reset to 0, so the first release after reset is a rising
    // edge and never counts as a press.
    assign press  = keyPrev & ~keyLvl;
    assign vsFall = vsR & ~vga.iVGA_VS;

    // FSM: state register
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) state <= WAIT_VS;
        else          state <= stateNext;
    end

    // FSM: next state
    always_comb begin
        stateNext = state;
        if (vsFall) begin
            stateNext = VSYNC;
        end else begin
            case (state)
                VSYNC:   if (vga.iVGA_VS)      stateNext = VBLANK;
                VBLANK:  if (vga.iVGA_BLANK_N) stateNext = ACTIVE;
                default: stateNext = state;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        countEn  = (state == VBLANK) || (state == ACTIVE);
        checkEn  = (state != WAIT_VS);
        isActive = (state == ACTIVE);
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            keyPrev    <= '0;
            vsR        <= 1'b0;
            pend_en    <= '0;
            ch_en      <= '0;
            x          <= '0;
            y          <= '0;
            pixX       <= '0;
            pixY       <= '0;
            pixValid   <= 1'b0;
            frameStart <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frameCnt   <= '0;
        end else begin
            keyPrev <= keyLvl;
            vsR     <= vga.iVGA_VS;

            // Load wins over increment when both land together.
            if (press[1])      pend_en <= swSync;
            else if (press[0]) pend_en <= pend_en + 3'd1;

            // Commit takes the pre-press value; a same-cycle press waits a frame.
            if (vsFall) ch_en <= pend_en;

            pixX       <= x;
            pixY       <= y;
            pixValid   <= vga.iVGA_BLANK_N;
            frameStart <= vga.iVGA_BLANK_N & ~pixValid & (y == '0) & checkEn;

            if (vsFall) begin
                x <= '0;
                y <= '0;
                if (checkEn) begin
                    frameCnt <= frameCnt + 8'd1;
                    // VSYNC/VBLANK here means no active lines at all.
                    if (!isActive || (y != Y_FULL)) frame_err <= 1'b1;
                end
            end else if (countEn) begin
                if (vga.iVGA_BLANK_N) begin
                    // Overlong line: flag and pin x at WIDTH.
                    if (x == X_FULL) line_err <= 1'b1;
                    else             x <= x + 1'b1;
                end else if (pixValid) begin
                    // End of an active line: x already holds its pixel count.
                    if (x != X_FULL) line_err <= 1'b1;
                    x <= '0;
                    if (y != '1) y <= y + 1'b1;
                end
            end
        end
    end

    assign vga.pix_x       = pixX;
    assign vga.pix_y       = pixY;
    assign vga.pix_valid   = pixValid;
    assign vga.frame_start = frameStart;

    assign LEDR = {isActive, frameCnt[0], frame_err, line_err, pend_en, ch_en};
endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl with a 10x10 active area inside standard
// 640x480 porch/sync timing (170 cycles/line, 55 lines/frame).
module tb_filter_mode_ctrl;
    localparam int W      = 10;
    localparam int H      = 10;
    localparam int LINE   = 170;
    localparam int LINES  = 55;
    localparam int FRAME  = LINE * LINES;
    localparam int VACT0  = 35;

    logic       VGA_CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] KEY = 2'b11;
    logic [2:0] SW  = 3'b000;
    logic [2:0] ch_en, pend_en;
    logic       line_err, frame_err;
    logic [9:0] LEDR;

    filter_mode_ctrl_if #(.XW(4), .YW(4)) vga ();

    filter_mode_ctrl #(.WIDTH(W), .HEIGHT(H), .DEBOUNCE_CYC(4)) dut (
        .VGA_CLK(VGA_CLK), .reset_n(reset_n), .vga(vga),
        .KEY(KEY), .SW(SW), .ch_en(ch_en), .pend_en(pend_en),
        .line_err(line_err), .frame_err(frame_err), .LEDR(LEDR)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    int vectors = 0, miscompares = 0;
    int frameNo = -1, genCyc = 0, genX = 0, genY = 0;
    logic genBlank = 1'b0, genTracked = 1'b0;
    int fsCount = 0, maxX = 0, maxY = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame generator. Frame 5 carries an 11-pixel line (active line 3)
    // and only 9 active lines; total frame length is unchanged.
    initial begin
        vga.iVGA_HS = 1'b1; vga.iVGA_VS = 1'b1; vga.iVGA_BLANK_N = 1'b0;
        forever begin
            for (int ln = 0; ln < LINES; ln++) begin
                for (int c = 0; c < LINE; c++) begin
                    int nAct, wid;
                    logic act, bl;
                    @(negedge VGA_CLK);
                    if (ln == 0 && c == 0) begin
                        frameNo++;
                        genTracked = reset_n;
                    end
                    if (!reset_n) genTracked = 1'b0;
                    nAct = (frameNo == 5) ? H - 1 : H;
                    wid  = (frameNo == 5 && ln - VACT0 == 3) ? W + 1 : W;
                    act  = (ln >= VACT0) && (ln < VACT0 + nAct);
                    bl   = act && (c < wid);
                    vga.iVGA_VS      = (ln >= 2);
                    vga.iVGA_HS      = !(c >= 26 && c < 122);
                    vga.iVGA_BLANK_N = bl;
                    genCyc = ln * LINE + c;
                    genBlank = bl; genX = c; genY = ln - VACT0;
                end
            end
        end
    end

    // Behavioural model + per-cycle compare.
    // Key rule: a press is the first low sample of KEY seen through two
    // sync stages, so at edge e it uses KEY sampled at e-3 (high) and e-2 (low),
    // and a load uses SW sampled at e-2. Commit on VS high->low between samples.
    logic [2:0][1:0] kh = '0;
    logic [1:0][2:0] swh = '0;
    logic mVsPrev = 1'b0;
    logic [2:0] mCh = '0, mPend = '0;

    initial forever begin
        logic [1:0]  pr;
        logic [15:0] expV, actV, mask;
        logic        eValid, eFs;
        logic [3:0]  eX, eY;
        @(posedge VGA_CLK);
        if (!reset_n) begin
            kh = '0; swh = '0; mVsPrev = 1'b0; mCh = '0; mPend = '0;
            eValid = 1'b0; eFs = 1'b0; eX = '0; eY = '0;
        end else begin
            pr = kh[2] & ~kh[1];
            if (mVsPrev && !vga.iVGA_VS) mCh = mPend;
            if (pr[1])      mPend = swh[1];
            else if (pr[0]) mPend = mPend + 3'd1;
            kh  = {kh[1:0], KEY};
            swh = {swh[0], SW};
            mVsPrev = vga.iVGA_VS;
            eValid = genBlank;
            eX = genTracked ? 4'((genX > W) ? W : genX) : 4'd0;
            eY = genTracked ? 4'(genY) : 4'd0;
            eFs = genTracked && genBlank && genX == 0 && genY == 0;
        end
        #1;
        expV = {eValid, eFs, mCh, mPend, eX, eY};
        actV = {vga.pix_valid, vga.frame_start, ch_en, pend_en, vga.pix_x, vga.pix_y};
`ifdef FILTER_CTRL_DEBOUNCE_EN
        mask = {2'b11, 6'b000000, {8{eValid}}};
`else
        mask = {2'b11, 6'b111111, {8{eValid}}};
`endif
        check("cycle", 32'(actV & mask), 32'(expV & mask));
        if (vga.frame_start) fsCount++;
        if (vga.pix_valid && frameNo == 1) begin
            if (int'(vga.pix_x) > maxX) maxX = int'(vga.pix_x);
            if (int'(vga.pix_y) > maxY) maxY = int'(vga.pix_y);
        end
    end

    task automatic waitFrame(input int n);
        int budget = 0;
        while (frameNo < n && budget < 2 * FRAME) begin
            @(posedge VGA_CLK); budget++;
        end
        if (frameNo < n) check("frame_timeout", 32'(frameNo), 32'(n));
        repeat (10) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
    endtask

    task automatic waitCyc(input int target);
        int budget = 0;
        do begin
            @(posedge VGA_CLK); budget++;
        end while (genCyc != target && budget < 2 * FRAME);
        if (genCyc != target) check("cyc_timeout", 32'(genCyc), 32'(target));
    endtask

    task automatic press(input logic [1:0] mask);
        @(negedge VGA_CLK);
        KEY = ~mask;
        repeat (8) @(negedge VGA_CLK);
        KEY = 2'b11;
        repeat (8) @(negedge VGA_CLK);
    endtask

    initial begin
        repeat (3) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        check("rst_ledr", 32'(LEDR), 32'h0);
        check("rst_pix", 32'({vga.pix_valid, vga.frame_start, vga.pix_x, vga.pix_y}), 32'h0);
        @(posedge VGA_CLK); #5 reset_n = 1'b1;

        // Two clean frames; frame 1 is the first tracked one.
        waitFrame(2);
        check("fs_after_f1", 32'(fsCount), 32'd1);
        check("max_x", 32'(maxX), 32'd9);
        check("max_y", 32'(maxY), 32'd9);
        waitCyc(1000);
        @(negedge VGA_CLK);
`ifndef FILTER_CTRL_DEBOUNCE_EN
        press(2'b01); press(2'b01); press(2'b01);
        check("pend_3", 32'(pend_en), 32'd3);
        check("ch_hold", 32'(ch_en), 32'd0);
`else
        KEY = 2'b10; repeat (2) @(negedge VGA_CLK); KEY = 2'b11;
        repeat (20) @(negedge VGA_CLK);
        check("deb_glitch", 32'(pend_en), 32'd0);
        KEY = 2'b10; repeat (6) @(negedge VGA_CLK); KEY = 2'b11;
        repeat (20) @(negedge VGA_CLK);
        check("deb_press", 32'(pend_en), 32'd1);
`endif
        waitCyc(7000);
        @(negedge VGA_CLK);
        check("led_active", 32'(LEDR[9]), 32'd1);

        waitFrame(3);
        check("fs_after_f2", 32'(fsCount), 32'd2);
        check("errs_clean", 32'({line_err, frame_err}), 32'd0);
        check("frame_cnt0", 32'(LEDR[8]), 32'd0);
`ifndef FILTER_CTRL_DEBOUNCE_EN
        check("ch_3", 32'(ch_en), 32'd3);
        check("led_ch", 32'(LEDR[5:0]), 32'o33);

        SW = 3'b101;
        repeat (4) @(negedge VGA_CLK);
        press(2'b11);
        check("both_load", 32'(pend_en), 32'd5);
        press(2'b01); press(2'b01);
        check("pend_7", 32'(pend_en), 32'd7);
        press(2'b01);
        check("pend_wrap", 32'(pend_en), 32'd0);

        waitFrame(4);
        check("ch_0", 32'(ch_en), 32'd0);
        check("frame_cnt1", 32'(LEDR[8]), 32'd1);
        press(2'b01);
        check("pend_1", 32'(pend_en), 32'd1);
        // KEY low alongside cycle FRAME-2 lands the press on the VS fall edge.
        waitCyc(FRAME - 3);
        @(negedge VGA_CLK);
        KEY = 2'b10;
        repeat (8) @(negedge VGA_CLK);
        KEY = 2'b11;
        check("vsfall_ch_old", 32'(ch_en), 32'd1);
        check("vsfall_pend_new", 32'(pend_en), 32'd2);
`else
        check("deb_ch", 32'(ch_en), 32'd1);
`endif

        waitFrame(5);
        waitCyc(7000);
        @(negedge VGA_CLK);
        check("line_err_set", 32'({line_err, frame_err}), 32'b10);

        waitFrame(6);
`ifndef FILTER_CTRL_DEBOUNCE_EN
        check("ch_2", 32'(ch_en), 32'd2);
`endif
        check("both_err", 32'(LEDR[7:6]), 32'b11);
        waitCyc(3000);
        @(negedge VGA_CLK);
        check("err_sticky", 32'({line_err, frame_err}), 32'b11);

        @(posedge VGA_CLK); #5 reset_n = 1'b0;
        @(posedge VGA_CLK); #5 reset_n = 1'b1;
        @(negedge VGA_CLK);
        check("reset_clear", 32'({LEDR, ch_en, pend_en, line_err, frame_err}), 32'h0);

        waitFrame(7);
        repeat (100) @(negedge VGA_CLK);
        check("after_reset_errs", 32'({line_err, frame_err}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
